// File: rtl/intlv_pkg.sv
// Shared constants and state encoding for the byte-wide convolutional interleaver.
package intlv_pkg;

  localparam int NUM_BRANCH = 12;   // number of branches; branch 0 is a bypass
  localparam int DEPTH_UNIT = 17;   // delay increment per branch (used by the delay lines)
  localparam int PKT_LEN    = 204;  // bytes per packet, a multiple of NUM_BRANCH
  localparam int DATA_W     = 8;    // byte width

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/intlv_out_mux.sv
// Registered NUM_BRANCH:1 byte mux. Branch 0 has no storage, so its byte is
// taken straight from the input; the other branches supply their oldest byte.
module intlv_out_mux
  import intlv_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_i,
  input  logic [$clog2(NUM_BRANCH)-1:0] sel_i,
  input  logic [DATA_W-1:0]            bypass_i,
  input  logic [NUM_BRANCH*DATA_W-1:0] lines_i,
  output logic [DATA_W-1:0]            data_o
);

  localparam int SEL_W = $clog2(NUM_BRANCH);
  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

  logic [DATA_W-1:0] mux_s;
  logic [DATA_W-1:0] data_q;

  // Pick the byte for the selected branch; branch 0 takes the bypass byte.
  always_comb begin
    mux_s = lines_i[DATA_W-1:0];
    if (sel_i == SEL_ZERO) begin
      mux_s = bypass_i;
    end else begin
      for (int j = 1; j < NUM_BRANCH; j++) begin
        if (sel_i == SEL_W'(j)) begin
          mux_s = lines_i[j*DATA_W +: DATA_W];
        end else begin
          mux_s = mux_s;
        end
      end
    end
  end

  // Capture the selected byte on every accepted byte; hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {DATA_W{1'b0}};
    end else if (load_i) begin
      data_q <= mux_s;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/conv_intlv_commutator.sv
// Input/output commutator and sequencer for the convolutional interleaver.
// Steers accepted bytes round-robin into the branch delay lines, muxes the
// oldest byte of the selected branch to the output, and keeps the branch
// pointer aligned so that every packet sync byte enters branch 0.
module conv_intlv_commutator
  import intlv_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_sync,
  output logic [DATA_W-1:0]            branch_din,
  output logic [NUM_BRANCH-1:0]        branch_en,
  input  logic [NUM_BRANCH*DATA_W-1:0] branch_dout,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sync,
  output logic                         locked,
  output logic                         sync_err
);

  localparam int PTR_W = $clog2(NUM_BRANCH);
  localparam int CNT_W = $clog2(PKT_LEN);

  localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_BRANCH - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [NUM_BRANCH-1:0] EN_ONE   = {{(NUM_BRANCH-1){1'b0}}, 1'b1};
  localparam logic [NUM_BRANCH-1:0] EN_ZERO  = {NUM_BRANCH{1'b0}};

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  br_ptr_q, br_ptr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              out_valid_q, out_sync_q, sync_err_q;

  logic [PTR_W-1:0]      ptr_eff_s;
  logic [CNT_W-1:0]      cnt_eff_s;
  logic                  missing_sync_s;
  logic                  early_sync_s;
  logic                  accept_s;
  logic [NUM_BRANCH-1:0] branch_en_s;

  // A sync byte always realigns to branch 0, count 0.
  assign ptr_eff_s = in_sync ? PTR_ZERO : br_ptr_q;
  assign cnt_eff_s = in_sync ? CNT_ZERO : byte_cnt_q;

  // A packet boundary reached without sync drops the byte and loses lock;
  // a sync arriving mid-packet is accepted but flagged.
  assign missing_sync_s = in_valid && (state_q == RUN) && !in_sync && (byte_cnt_q == CNT_ZERO);
  assign early_sync_s   = in_valid && (state_q == RUN) &&  in_sync && (byte_cnt_q != CNT_ZERO);
  assign accept_s       = in_valid && (in_sync || (state_q == RUN)) && !missing_sync_s;

  // State, branch pointer and byte counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      br_ptr_q   <= PTR_ZERO;
      byte_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      br_ptr_q   <= br_ptr_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next state: advance pointer and count on accept, fall back to HUNT on a missing sync.
  always_comb begin
    state_d    = state_q;
    br_ptr_d   = br_ptr_q;
    byte_cnt_d = byte_cnt_q;
    if (accept_s) begin
      state_d    = RUN;
      br_ptr_d   = (ptr_eff_s == PTR_LAST) ? PTR_ZERO : (ptr_eff_s + PTR_W'(1));
      byte_cnt_d = (cnt_eff_s == CNT_LAST) ? CNT_ZERO : (cnt_eff_s + CNT_W'(1));
    end else if (missing_sync_s) begin
      state_d    = HUNT;
      br_ptr_d   = PTR_ZERO;
      byte_cnt_d = CNT_ZERO;
    end else begin
      state_d    = state_q;
    end
  end

  // Shift enable for the selected branch; branch 0 has no storage and is never enabled.
  always_comb begin
    branch_en_s = EN_ZERO;
    if (accept_s && (ptr_eff_s != PTR_ZERO)) begin
      branch_en_s = EN_ONE << ptr_eff_s;
    end else begin
      branch_en_s = EN_ZERO;
    end
  end

  // Output strobes, registered on the same edge that shifts the branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      out_valid_q <= accept_s;
      out_sync_q  <= accept_s && (ptr_eff_s == PTR_ZERO) && (cnt_eff_s == CNT_ZERO);
      sync_err_q  <= early_sync_s || missing_sync_s;
    end
  end

  intlv_out_mux u_out_mux (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept_s),
    .sel_i    (ptr_eff_s),
    .bypass_i (in_data),
    .lines_i  (branch_dout),
    .data_o   (out_data)
  );

  assign branch_din = in_data;
  assign branch_en  = branch_en_s;
  assign out_valid  = out_valid_q;
  assign out_sync   = out_sync_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_conv_intlv_commutator.sv
// Scoreboard bench for conv_intlv_commutator. The stimulus process predicts
// each accepted byte and queues it; a negedge monitor pops and compares every
// out_valid beat. Branch delay lines are stubbed: branch j returns 0xA0+j.
module tb_conv_intlv_commutator;

  localparam int NB = 12;
  localparam int DW = 8;
  localparam int PL = 204;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_sync;
  logic [DW-1:0]   branch_din;
  logic [NB-1:0]   branch_en;
  logic [NB*DW-1:0] branch_dout;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sync;
  logic            locked;
  logic            sync_err;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  // reference model of the sequencer
  int m_state = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  conv_intlv_commutator dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sync     (in_sync),
    .branch_din  (branch_din),
    .branch_en   (branch_en),
    .branch_dout (branch_dout),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sync    (out_sync),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int j = 0; j < NB; j++) branch_dout[j*DW +: DW] = 8'(8'hA0 + j);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output beat must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out_valid=1 data=%0h expected no output at %0t", out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e[8:1]));
        chk("out_sync", 32'(out_sync), 32'(mon_e[0]));
      end
    end
  end

  // Present one input cycle; called at posedge+1, returns at the next posedge+1.
  task automatic send(input logic v, input logic [7:0] d, input logic s);
    logic missing, accept, err;
    int pe, ce;
    logic [NB-1:0] een;
    missing = v && (m_state == 1) && !s && (m_cnt == 0);
    accept  = v && (s || (m_state == 1)) && !missing;
    err     = v && (m_state == 1) && ((s && (m_cnt != 0)) || missing);
    pe = s ? 0 : m_ptr;
    ce = s ? 0 : m_cnt;
    een = (accept && pe != 0) ? (12'd1 << pe) : 12'd0;
    in_valid = v;
    in_data  = d;
    in_sync  = s;
    @(negedge clk);
    chk("branch_en", 32'(branch_en), 32'(een));
    chk("branch_din", 32'(branch_din), 32'(d));
    if (accept) exp_q.push_back({((pe == 0) ? d : 8'(8'hA0 + pe)), (pe == 0 && ce == 0)});
    if (accept) begin
      m_state = 1;
      m_ptr   = (pe + 1) % NB;
      m_cnt   = (ce + 1) % PL;
    end else if (missing) begin
      m_state = 0;
      m_ptr   = 0;
      m_cnt   = 0;
    end
    @(posedge clk);
    #1;
    chk("sync_err", 32'(sync_err), 32'(err));
    chk("locked", 32'(locked), 32'(m_state == 1));
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_sync  = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sync", 32'(out_sync), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_branch_en", 32'(branch_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // HUNT: non-sync bytes are dropped
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'(8'h10 + i), 1'b0);
      chk("hunt_out_valid", 32'(out_valid), 32'd0);
    end

    // lock on sync, then a full 204-byte packet
    send(1'b1, 8'h47, 1'b1);
    chk("lock_after_sync", 32'(locked), 32'd1);
    for (int i = 1; i < PL; i++) send(1'b1, 8'(i), 1'b0);

    // next packet on time, early sync at byte 100
    send(1'b1, 8'h47, 1'b1);
    for (int i = 1; i < 100; i++) send(1'b1, 8'(i), 1'b0);
    send(1'b1, 8'h55, 1'b1);
    chk("early_sync_err", 32'(sync_err), 32'd1);
    chk("early_locked", 32'(locked), 32'd1);
    for (int i = 1; i < PL; i++) send(1'b1, 8'(8'h80 + i), 1'b0);

    // byte 204 without sync: lock lost
    send(1'b1, 8'h99, 1'b0);
    chk("missing_sync_err", 32'(sync_err), 32'd1);
    chk("missing_locked", 32'(locked), 32'd0);
    chk("missing_out_valid", 32'(out_valid), 32'd0);

    // relock, then gapped traffic
    send(1'b1, 8'h47, 1'b1);
    for (int i = 0; i < 30; i++) begin
      send(1'b0, 8'hEE, 1'b0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      send(1'b1, 8'(8'h30 + i), 1'b0);
    end

    // asynchronous reset mid-packet
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_sync", 32'(out_sync), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_sync_err", 32'(sync_err), 32'd0);
    m_state = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // recover after reset and drain
    send(1'b1, 8'h22, 1'b0);
    send(1'b1, 8'h47, 1'b1);
    send(1'b1, 8'h01, 1'b0);
    send(1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 8'h00, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
